// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame constants
// used by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 868;
  localparam int unsigned UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line. Resets to 1 (line idle) so a
// reset never looks like a start bit to the receiver.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, finds the start bit, samples each bit at its
// centre, checks the stop bit and hands bytes out through a one-entry register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_due;
  logic                 stop_bit;

  uart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Receive FSM, bit timing and holding register. The stop bit is captured on
  // its centre edge and acted on one edge later.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      stop_due      <= 1'b0;
      stop_bit      <= 1'b0;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // LSB arrives first: shifting in from the top leaves it at bit 0.
        DATA: begin
          if (cnt == CNT_BIT) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (stop_due) begin
            stop_due <= 1'b0;
            cnt      <= '0;
            if (stop_bit) begin
              state <= IDLE;
              if (!valid || ready) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end else if (cnt == CNT_BIT) begin
            stop_due <= 1'b1;
            stop_bit <= rx_s;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // A held-low line (break) must return high before a new start counts.
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, 8 data bits.
module tb_uart_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned DB  = 8;
  // Pin edge first registered (P0) to valid rise: 2 sync + HALF + 9*CPB + 1.
  localparam int LAT = 155;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx;
  logic          ready;
  logic [DB-1:0] data;
  logic          valid;
  logic          framing_error;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .ready         (ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int       rise_cyc[$];
  logic [7:0] rise_data[$];
  int       vhigh   = 0;
  int       fe_cnt  = 0;
  int       fe_last = -1;
  int       ov_cnt  = 0;
  int       ov_last = -1;
  logic     valid_q = 1'b0;

  always @(negedge clock) begin
    if (valid && !valid_q) begin
      rise_cyc.push_back(cyc);
      rise_data.push_back(data);
    end
    if (valid) vhigh++;
    if (framing_error) begin
      fe_cnt++;
      fe_last = cyc;
    end
    if (overrun) begin
      ov_cnt++;
      ov_last = cyc;
    end
    valid_q = valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] data_at(input int i);
    if (i < rise_data.size()) return rise_data[i];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    if (i < rise_cyc.size()) return 32'(rise_cyc[i]);
    return 32'hxxxx_xxxx;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int p0);
    p0 = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, p1, p2;
    int b_r, b_v, b_fe, b_ov;

    rx    = 1'b1;
    ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ferr", 32'(framing_error), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle(5);

    // Single frame, consumer always ready
    b_r = rise_cyc.size(); b_v = vhigh; b_fe = fe_cnt; b_ov = ov_cnt;
    send_frame(8'hA5, 1'b1, p0);
    idle(20);
    check("a5_count", 32'(rise_cyc.size() - b_r), 32'd1);
    check("a5_data", 32'(data_at(b_r)), 32'hA5);
    check("a5_time", cyc_at(b_r), 32'(p0 + LAT));
    check("a5_width", 32'(vhigh - b_v), 32'd1);
    check("a5_ferr", 32'(fe_cnt - b_fe), 32'd0);
    check("a5_ovr", 32'(ov_cnt - b_ov), 32'd0);

    // Short glitch is rejected as a false start
    b_r = rise_cyc.size();
    rx = 1'b0;
    repeat (4) @(negedge clock);
    idle(200);
    check("glitch_none", 32'(rise_cyc.size() - b_r), 32'd0);
    send_frame(8'h3C, 1'b1, p0);
    idle(20);
    check("3c_count", 32'(rise_cyc.size() - b_r), 32'd1);
    check("3c_data", 32'(data_at(b_r)), 32'h3C);

    // Bad stop bit followed by a held-low line
    b_r = rise_cyc.size(); b_fe = fe_cnt;
    send_frame(8'h55, 1'b0, p0);
    rx = 1'b0;
    repeat (40) @(negedge clock);
    idle(20);
    check("ferr_count", 32'(fe_cnt - b_fe), 32'd1);
    check("ferr_time", 32'(fe_last), 32'(p0 + LAT));
    check("ferr_novalid", 32'(rise_cyc.size() - b_r), 32'd0);
    send_frame(8'h01, 1'b1, p0);
    idle(20);
    check("01_count", 32'(rise_cyc.size() - b_r), 32'd1);
    check("01_data", 32'(data_at(b_r)), 32'h01);
    check("01_ferr", 32'(fe_cnt - b_fe), 32'd1);

    // Overrun while the holding register is full
    ready = 1'b0;
    b_r = rise_cyc.size(); b_ov = ov_cnt;
    send_frame(8'h11, 1'b1, p1);
    idle(10);
    send_frame(8'h22, 1'b1, p2);
    idle(20);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_data", 32'(data), 32'h11);
    check("ovr_count", 32'(ov_cnt - b_ov), 32'd1);
    check("ovr_time", 32'(ov_last), 32'(p2 + LAT));
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    idle(5);
    check("drain_valid", 32'(valid), 32'd0);
    check("drain_data", 32'(data), 32'h11);
    check("drain_rises", 32'(rise_cyc.size() - b_r), 32'd1);

    // Back-to-back frames with no idle gap
    ready = 1'b1;
    b_r = rise_cyc.size();
    send_frame(8'h00, 1'b1, p1);
    send_frame(8'hFF, 1'b1, p2);
    idle(20);
    check("b2b_count", 32'(rise_cyc.size() - b_r), 32'd2);
    check("b2b_data0", 32'(data_at(b_r)), 32'h00);
    check("b2b_data1", 32'(data_at(b_r + 1)), 32'hFF);
    check("b2b_time0", cyc_at(b_r), 32'(p1 + LAT));
    check("b2b_space", cyc_at(b_r + 1) - cyc_at(b_r), 32'd160);

    // Reset during data bit 3 of 0x96 abandons the frame
    b_r = rise_cyc.size(); b_fe = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clock);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_ferr", 32'(framing_error), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle(32);
    check("mid_rst_none", 32'(rise_cyc.size() - b_r), 32'd0);
    send_frame(8'h7E, 1'b1, p0);
    idle(20);
    check("7e_count", 32'(rise_cyc.size() - b_r), 32'd1);
    check("7e_data", 32'(data_at(b_r)), 32'h7E);
    check("7e_time", cyc_at(b_r), 32'(p0 + LAT));
    check("7e_ferr", 32'(fe_cnt - b_fe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
